i2c_cmd_queue: RTL

I2C_CMD_QUEUE -- requirements
Module: i2c_cmd_queue

---
 rtl/i2c_cmd_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/i2c_cmd_queue.sv
// Command FIFO feeding an I2C master: queues {address, rw} entries and issues them
// one at a time with an enable strobe, waiting for the master's busy cycle or a timeout.
module i2c_cmd_queue #(
  parameter int DEPTH     = 4,
  parameter int EN_CYCLES = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [6:0]             push_addr,
  input  logic                   push_rw,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   master_busy,
  output logic                   enable,
  output logic [6:0]             dest_address,
  output logic                   rw,
  output logic                   done,
  output logic                   timeout_err,
  output logic [2:0]             state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_PULSE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  // Handshakes: a push is taken on any rising edge with push=1 and full=0 (else dropped);
  // a command is started only from IDLE with busy low, and the master acknowledges it
  // by raising master_busy after enable, then lowering it when the transfer is over.

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, empty_q;
  logic [6:0]      dest_q;
  logic            rw_q;
  logic [PW-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            push_ok, pop, tmo_hit;

  always_comb begin
    push_ok  = push && !full_q;
    pop      = (state_q == S_LOAD);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    tmo_hit  = ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_IDLE)) &&
               (tmo_cnt_q == TW'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_addr, push_rw};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      dest_q      <= '0;
      rw_q        <= 1'b0;
      pulse_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == CW'(DEPTH));
      empty_q     <= (count_d == '0);
      pulse_cnt_q <= pulse_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      if (pop) {dest_q, rw_q} <= mem_q[rd_ptr_q];
    end
  end

  // In WAIT_BUSY an expired budget wins over a late busy; in WAIT_IDLE completion wins.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    case (state_q)
      S_IDLE: if (!empty_q && !master_busy) state_d = S_LOAD;
      S_LOAD: begin
        state_d     = S_PULSE;
        pulse_cnt_d = '0;
        tmo_cnt_d   = '0;
      end
      S_PULSE: begin
        if (pulse_cnt_q == PW'(EN_CYCLES - 1)) state_d = S_WAIT_BUSY;
        else pulse_cnt_d = pulse_cnt_q + PW'(1);
      end
      S_WAIT_BUSY: begin
        if (tmo_hit) state_d = S_IDLE;
        else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (master_busy) state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (!master_busy || tmo_hit) state_d = S_IDLE;
        else tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    enable       = (state_q == S_PULSE);
    done         = (state_q == S_WAIT_IDLE) && !master_busy;
    timeout_err  = tmo_hit && !done;
    full         = full_q;
    empty        = empty_q;
    count        = count_q;
    dest_address = dest_q;
    rw           = rw_q;
    state_dbg    = state_q;
  end

endmodule
